line_buffer_9rows: RTL and testbench

Streaming line buffer placed directly upstream of the 9x9 window buffer. It accepts one pixel per valid cycle in raster order and stores the previous 8 image rows in on-chip line memories. Each valid cycle it presents a vertically aligned column of 9 pixels on S1_o..S9_o, which the window buffer consumes on its S1_i..S9_i / done_i inputs. It also tracks frame position and signals frame completion.

---
 rtl/line_buffer_9rows.sv | 116 +++++++++++
 tb/tb_line_buffer_9rows.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/line_buffer_9rows.sv
// Streaming 8-line buffer that emits a vertically aligned 9-pixel column
// per accepted pixel, with frame position tracking and a frame-end pulse.
module line_buffer_9rows #(
  parameter int COLS       = 11,
  parameter int ROWS       = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] S1_o,
  output logic [DATA_WIDTH-1:0] S2_o,
  output logic [DATA_WIDTH-1:0] S3_o,
  output logic [DATA_WIDTH-1:0] S4_o,
  output logic [DATA_WIDTH-1:0] S5_o,
  output logic [DATA_WIDTH-1:0] S6_o,
  output logic [DATA_WIDTH-1:0] S7_o,
  output logic [DATA_WIDTH-1:0] S8_o,
  output logic [DATA_WIDTH-1:0] S9_o,
  output logic                  done_o,
  output logic                  progress_done_o
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_FULL = RW'(8);

  logic [DATA_WIDTH-1:0] line_q [8][COLS];

  logic [CW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] s_q [9];
  logic [DATA_WIDTH-1:0] s_d [9];
  logic                  done_q, done_d;
  logic                  prog_q, prog_d;
  logic                  last_col;
  logic                  last_pix;

  assign last_col = (col_q == COL_LAST);
  assign last_pix = last_col && (row_q == ROW_LAST);

  // Line memories shift one row downward at the shared pointer; no reset so
  // they map onto plain RAM.
  always_ff @(posedge clk) begin
    if (done_i) begin
      line_q[0][ptr_q] <= data_i;
      for (int unsigned k = 1; k < 8; k++) begin
        line_q[k][ptr_q] <= line_q[k-1][ptr_q];
      end
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    col_d  = col_q;
    row_d  = row_q;
    s_d    = s_q;
    done_d = 1'b0;
    prog_d = 1'b0;
    if (done_i) begin
      s_d[8] = data_i;
      for (int unsigned k = 0; k < 8; k++) begin
        s_d[7-k] = line_q[k][ptr_q];
      end
      done_d = (row_q >= ROW_FULL);
      prog_d = last_pix;
      ptr_d  = (ptr_q == COL_LAST) ? '0 : ptr_q + 1'b1;
      if (last_col) begin
        col_d = '0;
        row_d = last_pix ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (last_pix) ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q  <= '0;
      col_q  <= '0;
      row_q  <= '0;
      done_q <= 1'b0;
      prog_q <= 1'b0;
      for (int unsigned k = 0; k < 9; k++) begin
        s_q[k] <= '0;
      end
    end else begin
      ptr_q  <= ptr_d;
      col_q  <= col_d;
      row_q  <= row_d;
      done_q <= done_d;
      prog_q <= prog_d;
      for (int unsigned k = 0; k < 9; k++) begin
        s_q[k] <= s_d[k];
      end
    end
  end

  assign S1_o            = s_q[0];
  assign S2_o            = s_q[1];
  assign S3_o            = s_q[2];
  assign S4_o            = s_q[3];
  assign S5_o            = s_q[4];
  assign S6_o            = s_q[5];
  assign S7_o            = s_q[6];
  assign S8_o            = s_q[7];
  assign S9_o            = s_q[8];
  assign done_o          = done_q;
  assign progress_done_o = prog_q;

endmodule

// File: tb/tb_line_buffer_9rows.sv
// Directed bench for line_buffer_9rows: reset, fill, stall, frame end and
// mid-frame reset with an 11x11 frame of pixel-index data.
module tb_line_buffer_9rows;

  logic       clk;
  logic       rst;
  logic       done_i;
  logic [7:0] data_i;
  logic [7:0] S1_o, S2_o, S3_o, S4_o, S5_o, S6_o, S7_o, S8_o, S9_o;
  logic       done_o;
  logic       progress_done_o;
  logic [7:0] s_obs [9];

  int checks = 0;
  int passes = 0;

  line_buffer_9rows #(
    .COLS(11),
    .ROWS(11),
    .DATA_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .done_i(done_i),
    .data_i(data_i),
    .S1_o(S1_o),
    .S2_o(S2_o),
    .S3_o(S3_o),
    .S4_o(S4_o),
    .S5_o(S5_o),
    .S6_o(S6_o),
    .S7_o(S7_o),
    .S8_o(S8_o),
    .S9_o(S9_o),
    .done_o(done_o),
    .progress_done_o(progress_done_o)
  );

  assign s_obs[0] = S1_o;
  assign s_obs[1] = S2_o;
  assign s_obs[2] = S3_o;
  assign s_obs[3] = S4_o;
  assign s_obs[4] = S5_o;
  assign s_obs[5] = S6_o;
  assign s_obs[6] = S7_o;
  assign s_obs[7] = S8_o;
  assign s_obs[8] = S9_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Column whose bottom pixel is index p: S_n = p - 11*(9-n)
  task automatic chk_col(input string tag, input int p);
    for (int n = 0; n < 9; n++) begin
      chk($sformatf("%s_S%0d", tag, n + 1), int'(s_obs[n]), (p - 11 * (8 - n)) % 256);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int n = 0; n < 9; n++) begin
      chk($sformatf("%s_S%0d", tag, n + 1), int'(s_obs[n]), 0);
    end
    chk({tag, "_done"}, int'(done_o), 0);
    chk({tag, "_prog"}, int'(progress_done_o), 0);
  endtask

  task automatic push(input int pix);
    @(negedge clk);
    done_i = 1'b1;
    data_i = 8'(pix);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    done_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b0;
    done_i = 1'b0;
    data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst_hold");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("rst_rel");

    // Fill: no valid column until pixel 88
    for (int p = 0; p < 88; p++) begin
      push(p);
      chk($sformatf("fill_done_p%0d", p), int'(done_o), 0);
      chk($sformatf("fill_s9_p%0d", p), int'(S9_o), p);
    end
    push(88);
    chk("first_done", int'(done_o), 1);
    chk_col("first_col", 88);
    push(89);
    chk("second_done", int'(done_o), 1);
    chk_col("second_col", 89);
    for (int p = 90; p <= 95; p++) begin
      push(p);
      chk($sformatf("run_done_p%0d", p), int'(done_o), 1);
      chk($sformatf("run_s9_p%0d", p), int'(S9_o), p);
    end

    // Stall: outputs hold, done_o drops
    for (int i = 0; i < 5; i++) begin
      idle();
      chk($sformatf("stall_done_%0d", i), int'(done_o), 0);
      chk($sformatf("stall_prog_%0d", i), int'(progress_done_o), 0);
      chk_col($sformatf("stall_col_%0d", i), 95);
    end
    push(96);
    chk("resume_done", int'(done_o), 1);
    chk_col("resume_col", 96);

    // Through frame end
    for (int p = 97; p < 120; p++) begin
      push(p);
      chk($sformatf("tail_done_p%0d", p), int'(done_o), 1);
      chk($sformatf("tail_prog_p%0d", p), int'(progress_done_o), 0);
      chk($sformatf("tail_s1_p%0d", p), int'(S1_o), p - 88);
    end
    push(120);
    chk("end_prog", int'(progress_done_o), 1);
    chk("end_done", int'(done_o), 1);
    chk_col("end_col", 120);

    // Frame 2 refill: stale lines never flagged
    for (int p = 0; p < 88; p++) begin
      push(p);
      chk($sformatf("f2_done_p%0d", p), int'(done_o), 0);
      chk($sformatf("f2_prog_p%0d", p), int'(progress_done_o), 0);
    end
    for (int p = 88; p <= 100; p++) begin
      push(p);
      chk($sformatf("f2_done_p%0d", p), int'(done_o), 1);
      chk($sformatf("f2_s1_p%0d", p), int'(S1_o), p - 88);
    end
    chk_col("f2_col100", 100);

    // Mid-frame reset clears immediately, asynchronously
    @(negedge clk);
    done_i = 1'b0;
    rst    = 1'b0;
    #1;
    chk_zero("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    for (int p = 0; p < 88; p++) begin
      push(p);
      chk($sformatf("f3_done_p%0d", p), int'(done_o), 0);
    end
    push(88);
    chk("f3_first_done", int'(done_o), 1);
    chk_col("f3_first_col", 88);
    idle();
    chk("f3_idle_done", int'(done_o), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
